pinky_regread_stage: RTL and testbench
======================================

Name: pinky_regread_stage

Overview:
- Parametrised operand-fetch stage for the PinKY pipeline, placed between instruction fetch and the ALU stage.
- Holds the register file and a write-back port with same-cycle bypass.
- Resolves PRE-extended and sign-extended immediates, consumes PRE instructions internally, and registers decoded operands behind a valid/ready handshake with flush.
- Generalises the fixed 16-register, no-stall operand stage: adds parametrised width and depth, backpressure, flush, and PC-register reads.

Parameters:
- WIDTH, 16, data/register width in bits; must be >= 16.
- NREGS, 16, register count; power of two, <= 16 (4-bit register fields).
- PC_REG, 15, register index whose reads return in_pc instead of array contents.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_ir/in_pc carry an instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_ir  input  16  instruction word: opcode[15:11], cc[10:9], imm[8], dest[7:4], op2[3:0].
- in_pc  input  WIDTH  address of in_ir.
- flush  input  1  squash the pipeline register and pending prefix.
- wb_en  input  1  register write enable from the final stage.
- wb_dest  input  4  write index; indices >= NREGS and PC_REG are ignored.
- wb_data  input  WIDTH  write data.
- out_valid  output  1  output bundle is valid.
- out_ready  input  1  downstream accepts the bundle.
- out_ir  output  16  registered instruction.
- out_pc  output  WIDTH  registered PC.
- out_rd  output  WIDTH  value of register dest.
- out_op2  output  WIDTH  resolved second operand.

Behaviour:
- Clocking and reset: all state updates on posedge clk; reset is synchronous and active-high and overrides every other input.
- Reset values: out_valid=0, out_ir=0, out_pc=0, out_rd=0, out_op2=0, all registers=0, pre_valid=0, pre=0.
- Handshake: in_ready = out_ready | ~out_valid (combinational). Accept = in_valid & in_ready & ~flush.
- Output register on Accept of a non-PRE instruction: out_valid<=1 and out_ir/out_pc/out_rd/out_op2 are loaded. Latency is one cycle.
- Output register hold/drain:
  - If out_valid & ~out_ready, all out_* hold stable.
  - If out_ready & no Accept, out_valid<=0.
- PRE instruction (in_ir[15:14]==2'b11): on Accept, pre<=in_ir[11:0] and pre_valid<=1. It produces no output bundle (out_valid<=0 if draining). A second PRE overwrites the first.
- Operand read: rd index = in_ir[7:4]; op2 register index = in_ir[3:0].
  - Index == PC_REG returns in_pc.
  - Index >= NREGS returns 0.
  - Otherwise the register file is read.
- Bypass: if wb_en and wb_dest equals a read index (not PC_REG, < NREGS) in the same cycle, wb_data is returned instead of the array value.
- op2 resolution:
  - imm=0: register value.
  - imm=1 & pre_valid: {pre, in_ir[3:0]} zero-extended to WIDTH.
  - imm=1 & ~pre_valid: in_ir[3:0] sign-extended to WIDTH.
  - Accepting any imm=1 instruction clears pre_valid. imm=0 instructions leave it unchanged.
- Register write: with wb_en, regs[wb_dest]<=wb_data at posedge, independent of stall and flush.
- Flush: next cycle out_valid=0 and pre_valid=0, and the in_ir presented that cycle is dropped. Flush wins over a simultaneous Accept. Data outputs hold their old values.
- Reset during a stall or flush: reset wins, and all reset values apply the next cycle.
- Opcode and cc are not interpreted beyond PRE detection; NOP and SYS pass through unchanged.

Test Plan:
1. Reset then read:
   - Stimulus: reset 1 cycle; then in_ir=0x0012 (ADD, dest1, reg op2=2), in_valid=1, out_ready=1.
   - Required: next cycle out_valid=1, out_rd=0, out_op2=0; before the first accept, all outputs are 0.
2. Bypass:
   - Stimulus: wb_en=1, wb_dest=3, wb_data=0xBEEF in the same cycle as in_ir=0x0033.
   - Required: out_rd=0xBEEF, out_op2=0xBEEF. A later read of r3 without wb returns 0xBEEF.
3. Immediates:
   - Stimulus: in_ir=0x010F; next, PRE 0xCABC followed by in_ir=0x0105; then in_ir=0x0105 again.
   - Required: op2 outputs are 0xFFFF, 0xABC5, 0x0005 respectively. The PRE produces no out_valid pulse.
4. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles with a valid output held and a new instruction presented.
   - Required: in_ready=0 and out_* stable for all 3 cycles. On out_ready=1 the new bundle appears one cycle later. No loss or duplication over a 20-instruction random-stall run.
5. Flush:
   - Stimulus: PRE 0xC123, then flush=1 together with in_ir=0x0104.
   - Required: out_valid=0 next cycle and the instruction is dropped. The following in_ir=0x0104 gives out_op2=0x0004 (prefix cleared).
6. PC register and ignored writes:
   - Stimulus: in_pc=0x0042, in_ir=0x00F0 (dest=r15); separately wb_en to wb_dest=15.
   - Required: out_rd=0x0042; the wb to 15 is ignored. With NREGS=8, a read of r9 returns 0.

Source files
------------

// File: rtl/pinky_regread_stage.sv
// Operand-fetch stage: register file with write-back bypass, PRE/immediate resolution, registered output.
// Latency 1 cycle; in_ready = out_ready | ~out_valid, output bundle holds while stalled.
module pinky_regread_stage #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 16,
    parameter int PC_REG = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_ir,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             flush,
    input  logic             wb_en,
    input  logic [3:0]       wb_dest,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_ir,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_rd,
    output logic [WIDTH-1:0] out_op2
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [3:0] PC_IDX = 4'(PC_REG);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_ir_q, out_ir_d;
    logic [WIDTH-1:0] out_pc_q, out_pc_d;
    logic [WIDTH-1:0] out_rd_q, out_rd_d;
    logic [WIDTH-1:0] out_op2_q, out_op2_d;
    logic             pre_valid_q, pre_valid_d;
    logic [11:0]      pre_q, pre_d;

    logic             wb_ok;
    logic             accept;
    logic             is_pre;
    logic [3:0]       rd_idx, op_idx;
    logic [WIDTH-1:0] rd_val, op_reg, op2_val;

    assign in_ready = out_ready | ~out_valid_q;
    assign accept   = in_valid & in_ready & ~flush;
    assign is_pre   = (in_ir[15:14] == 2'b11);
    assign rd_idx   = in_ir[7:4];
    assign op_idx   = in_ir[3:0];

    // Writes to the PC alias or beyond the array are dropped, so they never bypass either.
    assign wb_ok = wb_en && (32'(wb_dest) < NREGS) && (wb_dest != PC_IDX);

    always_comb begin
        rd_val = '0;
        if (rd_idx == PC_IDX) begin
            rd_val = in_pc;
        end else if (32'(rd_idx) < NREGS) begin
            rd_val = (wb_ok && (wb_dest == rd_idx)) ? wb_data : regs_q[rd_idx[AW-1:0]];
        end
    end

    always_comb begin
        op_reg = '0;
        if (op_idx == PC_IDX) begin
            op_reg = in_pc;
        end else if (32'(op_idx) < NREGS) begin
            op_reg = (wb_ok && (wb_dest == op_idx)) ? wb_data : regs_q[op_idx[AW-1:0]];
        end
    end

    always_comb begin
        op2_val = op_reg;
        if (in_ir[8]) begin
            if (pre_valid_q) begin
                op2_val = WIDTH'({pre_q, in_ir[3:0]});
            end else begin
                op2_val = {{(WIDTH-4){in_ir[3]}}, in_ir[3:0]};
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_ok) begin
            regs_d[wb_dest[AW-1:0]] = wb_data;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_ir_d    = out_ir_q;
        out_pc_d    = out_pc_q;
        out_rd_d    = out_rd_q;
        out_op2_d   = out_op2_q;
        pre_valid_d = pre_valid_q;
        pre_d       = pre_q;
        if (flush) begin
            out_valid_d = 1'b0;
            pre_valid_d = 1'b0;
        end else if (accept && is_pre) begin
            out_valid_d = 1'b0;
            pre_valid_d = 1'b1;
            pre_d       = in_ir[11:0];
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ir_d    = in_ir;
            out_pc_d    = in_pc;
            out_rd_d    = rd_val;
            out_op2_d   = op2_val;
            if (in_ir[8]) begin
                pre_valid_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_ir_q    <= '0;
            out_pc_q    <= '0;
            out_rd_q    <= '0;
            out_op2_q   <= '0;
            pre_valid_q <= 1'b0;
            pre_q       <= '0;
        end else begin
            regs_q      <= regs_d;
            out_valid_q <= out_valid_d;
            out_ir_q    <= out_ir_d;
            out_pc_q    <= out_pc_d;
            out_rd_q    <= out_rd_d;
            out_op2_q   <= out_op2_d;
            pre_valid_q <= pre_valid_d;
            pre_q       <= pre_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ir    = out_ir_q;
    assign out_pc    = out_pc_q;
    assign out_rd    = out_rd_q;
    assign out_op2   = out_op2_q;
endmodule

// File: tb/tb_pinky_regread_stage.sv
// Directed bench for pinky_regread_stage: default instance plus an NREGS=8 instance on shared inputs.
module tb_pinky_regread_stage;
    logic        clk = 1'b0;
    logic        reset, in_valid, flush, wb_en, out_ready;
    logic [15:0] in_ir, in_pc, wb_data;
    logic [3:0]  wb_dest;
    logic        in_ready, out_valid;
    logic [15:0] out_ir, out_pc, out_rd, out_op2;
    logic        in_ready8, out_valid8;
    logic [15:0] out_ir8, out_pc8, out_rd8, out_op28;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pinky_regread_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
        .out_rd(out_rd), .out_op2(out_op2)
    );

    pinky_regread_stage #(.WIDTH(16), .NREGS(8), .PC_REG(15)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .out_valid(out_valid8),
        .out_ready(out_ready), .out_ir(out_ir8), .out_pc(out_pc8),
        .out_rd(out_rd8), .out_op2(out_op28)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int rcv;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        in_ir = '0; in_pc = '0; wb_data = '0; wb_dest = '0;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ir", out_ir, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_op2", out_op2, 0);
        check("rst_in_ready", in_ready, 1);

        // reset then read
        reset = 1'b0; in_valid = 1'b1; in_ir = 16'h0012; in_pc = 16'h0010;
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_rd", out_rd, 0);
        check("t1_op2", out_op2, 0);
        check("t1_ir", out_ir, 16'h0012);
        check("t1_pc", out_pc, 16'h0010);
        in_valid = 1'b0;
        tick();
        check("t1_drain", out_valid, 0);

        // bypass
        in_valid = 1'b1; in_ir = 16'h0033; wb_en = 1'b1; wb_dest = 4'd3; wb_data = 16'hBEEF;
        tick();
        check("t2_byp_rd", out_rd, 16'hBEEF);
        check("t2_byp_op2", out_op2, 16'hBEEF);
        wb_en = 1'b0; in_ir = 16'h0032;
        tick();
        check("t2_reg_rd", out_rd, 16'hBEEF);
        check("t2_reg_op2", out_op2, 0);

        // immediates
        in_ir = 16'h010F;
        tick();
        check("t3_sext", out_op2, 16'hFFFF);
        in_ir = 16'hCABC;
        tick();
        check("t3_pre_novalid", out_valid, 0);
        in_ir = 16'h0105;
        tick();
        check("t3_pre_op2", out_op2, 16'hABC5);
        check("t3_pre_valid", out_valid, 1);
        tick();
        check("t3_cleared_op2", out_op2, 16'h0005);

        // backpressure
        in_ir = 16'h0012; in_pc = 16'h0020;
        tick();
        check("t4_first_ir", out_ir, 16'h0012);
        out_ready = 1'b0; in_ir = 16'h0033; in_pc = 16'h0024;
        #1;
        check("t4_in_ready_lo", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_ir", out_ir, 16'h0012);
            check("t4_hold_pc", out_pc, 16'h0020);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check("t4_next_ir", out_ir, 16'h0033);
        check("t4_next_pc", out_pc, 16'h0024);
        check("t4_next_rd", out_rd, 16'hBEEF);
        in_valid = 1'b0;
        tick();
        check("t4_drained", out_valid, 0);

        sent = 0;
        rcv = 0;
        in_ir = 16'h0012;
        for (int cyc = 0; cyc < 400 && rcv < 20; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 20);
            in_pc     = 16'(16'h0100 + sent);
            #1;
            if (out_valid && out_ready) begin
                check("t4_stream_order", out_pc, 32'(16'h0100 + rcv));
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        check("t4_stream_count", rcv, 20);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("t4_stream_idle", out_valid, 0);

        // flush
        in_valid = 1'b1; in_ir = 16'hC123;
        tick();
        check("t5_pre_novalid", out_valid, 0);
        flush = 1'b1; in_ir = 16'h0104;
        tick();
        check("t5_flush_drop", out_valid, 0);
        flush = 1'b0;
        tick();
        check("t5_after_valid", out_valid, 1);
        check("t5_after_op2", out_op2, 16'h0004);
        out_ready = 1'b0; in_ir = 16'h0012; flush = 1'b1;
        tick();
        check("t5_stall_flush_valid", out_valid, 0);
        check("t5_stall_flush_hold", out_ir, 16'h0104);
        flush = 1'b0; out_ready = 1'b1;

        // PC register and ignored writes
        in_pc = 16'h0042; in_ir = 16'h00F0; wb_en = 1'b1; wb_dest = 4'd15; wb_data = 16'h1234;
        tick();
        check("t6_pc_rd", out_rd, 16'h0042);
        check("t6_pc_rd8", out_rd8, 16'h0042);
        wb_en = 1'b0; in_pc = 16'h0050;
        tick();
        check("t6_pc_ignored_wb", out_rd, 16'h0050);
        in_valid = 1'b0; wb_en = 1'b1; wb_dest = 4'd9; wb_data = 16'h5555;
        tick();
        wb_en = 1'b0; in_valid = 1'b1; in_ir = 16'h0099; in_pc = 16'h0060;
        tick();
        check("t6_r9_rd16", out_rd, 16'h5555);
        check("t6_r9_rd8", out_rd8, 0);
        check("t6_r9_op2_8", out_op28, 0);
        check("t6_valid8", out_valid8, 1);

        // reset during a stall
        in_ir = 16'h0012;
        tick();
        out_ready = 1'b0; reset = 1'b1;
        tick();
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_pc", out_pc, 0);
        reset = 1'b0; out_ready = 1'b1; in_ir = 16'h0033;
        tick();
        check("t7_regs_cleared", out_rd, 0);
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
